// File: rtl/bsg_dmc_ui_master.sv
// ---------------------------------------------------------------------------
// bsg_dmc_ui_master
//
// Turns a single-line request (read or write) into the DMC application
// user-interface protocol. Exactly one request is in flight at a time.
//
// Ports
//   clk_i, reset_i            UI clock and asynchronous active-high reset
//   init_calib_complete_i     DMC calibration done; gates new requests only
//   req_*                     request channel (valid/ready), one full line
//   resp_*                    response channel (valid/ready), read line or
//                             a zero line for write acknowledgements
//   error_o                   sticky protocol error (stray or misframed beat)
//   app_addr_o/cmd_o/en_o     DMC command port, app_rdy_i is its ready
//   app_wdf_*                 DMC write-data port, app_wdf_rdy_i is its ready
//   app_rd_data_*             DMC read-data return port
// ---------------------------------------------------------------------------
module bsg_dmc_ui_master #(
  parameter int ui_addr_width_p = 28,
  parameter int ui_data_width_p = 128,
  parameter int burst_len_p     = 2,
  localparam int ui_mask_width_lp = ui_data_width_p >> 3,
  localparam int line_width_lp    = burst_len_p * ui_data_width_p
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    init_calib_complete_i,

  input  logic                                    req_v_i,
  output logic                                    req_ready_o,
  input  logic                                    req_write_i,
  input  logic [ui_addr_width_p-1:0]              req_addr_i,
  input  logic [line_width_lp-1:0]                req_data_i,
  input  logic [burst_len_p*ui_mask_width_lp-1:0] req_mask_i,

  output logic                                    resp_v_o,
  input  logic                                    resp_ready_i,
  output logic                                    resp_write_o,
  output logic [line_width_lp-1:0]                resp_data_o,

  output logic                                    error_o,

  output logic [ui_addr_width_p-1:0]              app_addr_o,
  output logic [2:0]                              app_cmd_o,
  output logic                                    app_en_o,
  input  logic                                    app_rdy_i,

  output logic                                    app_wdf_wren_o,
  output logic [ui_data_width_p-1:0]              app_wdf_data_o,
  output logic [ui_mask_width_lp-1:0]             app_wdf_mask_o,
  output logic                                    app_wdf_end_o,
  input  logic                                    app_wdf_rdy_i,

  input  logic                                    app_rd_data_valid_i,
  input  logic [ui_data_width_p-1:0]              app_rd_data_i,
  input  logic                                    app_rd_data_end_i
);

  // Beat counter is at least one bit wide so a single-beat burst still works.
  localparam int cnt_width_lp = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(burst_len_p - 1);
  localparam logic [cnt_width_lp-1:0] one_cnt_lp  = cnt_width_lp'(1);

  // RDCMD is the read command phase that precedes RDWAIT.
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WRITE  = 3'd1;
  localparam logic [2:0] RDCMD  = 3'd2;
  localparam logic [2:0] RDWAIT = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  localparam logic [2:0] cmd_write_lp = 3'b000;
  localparam logic [2:0] cmd_read_lp  = 3'b001;

  logic [2:0]                              state_q, state_d;
  logic [cnt_width_lp-1:0]                 cnt_q, cnt_d;
  logic                                    cmd_done_q, cmd_done_d;
  logic                                    data_done_q, data_done_d;
  logic                                    error_q, error_d;

  logic                                    write_q;
  logic [ui_addr_width_p-1:0]              addr_q;
  logic [line_width_lp-1:0]                data_q;
  logic [burst_len_p*ui_mask_width_lp-1:0] mask_q;
  logic [line_width_lp-1:0]                resp_data_q, resp_data_d;

  logic req_hs;
  logic cmd_hs;
  logic wdf_hs;
  logic cnt_last;
  logic rd_beat;

  assign cnt_last = (cnt_q == last_cnt_lp);

  assign req_ready_o = (state_q == IDLE) & init_calib_complete_i;
  assign req_hs      = req_v_i & req_ready_o;

  // The command stays up in WRITE until its own handshake, independent of
  // how far the write data has progressed.
  assign app_en_o   = ((state_q == WRITE) & ~cmd_done_q) | (state_q == RDCMD);
  assign app_cmd_o  = write_q ? cmd_write_lp : cmd_read_lp;
  assign app_addr_o = addr_q;
  assign cmd_hs     = app_en_o & app_rdy_i;

  assign app_wdf_wren_o = (state_q == WRITE) & ~data_done_q;
  assign app_wdf_data_o = data_q[cnt_q*ui_data_width_p +: ui_data_width_p];
  assign app_wdf_mask_o = mask_q[cnt_q*ui_mask_width_lp +: ui_mask_width_lp];
  assign app_wdf_end_o  = app_wdf_wren_o & cnt_last;
  assign wdf_hs         = app_wdf_wren_o & app_wdf_rdy_i;

  // A read beat is legal while waiting for data, or in the very cycle the
  // read command is taken. Any other beat cannot belong to a live request.
  assign rd_beat = app_rd_data_valid_i
                 & ((state_q == RDWAIT) | ((state_q == RDCMD) & cmd_hs));

  assign resp_v_o     = (state_q == RESP);
  assign resp_write_o = write_q;
  assign resp_data_o  = write_q ? '0 : resp_data_q;
  assign error_o      = error_q;

  // Next-state logic: the FSM, beat counter, command/data done flags,
  // the sticky error and the read-line assembly.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_done_d  = cmd_done_q;
    data_done_d = data_done_q;
    error_d     = error_q;
    resp_data_d = resp_data_q;

    case (state_q)
      IDLE: begin
        if (req_hs) begin
          state_d     = req_write_i ? WRITE : RDCMD;
          cnt_d       = '0;
          cmd_done_d  = 1'b0;
          data_done_d = 1'b0;
        end
      end

      WRITE: begin
        if (cmd_hs) begin
          cmd_done_d = 1'b1;
        end
        if (wdf_hs) begin
          if (cnt_last) begin
            data_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + one_cnt_lp;
          end
        end
        // Looking at the next-state flags lets both sides finish in the
        // same cycle and still reach RESP on the following one.
        if (cmd_done_d & data_done_d) begin
          state_d = RESP;
        end
      end

      RDCMD: begin
        if (cmd_hs) begin
          state_d = (rd_beat & cnt_last) ? RESP : RDWAIT;
        end
      end

      RDWAIT: begin
        if (rd_beat & cnt_last) begin
          state_d = RESP;
        end
      end

      RESP: begin
        if (resp_ready_i) begin
          state_d     = IDLE;
          cnt_d       = '0;
          cmd_done_d  = 1'b0;
          data_done_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Read beats land in the slot named by the counter; the framing bit
    // must agree with the counter's view of the last beat.
    if (rd_beat) begin
      resp_data_d[cnt_q*ui_data_width_p +: ui_data_width_p] = app_rd_data_i;
      if (app_rd_data_end_i != cnt_last) begin
        error_d = 1'b1;
      end
      if (!cnt_last) begin
        cnt_d = cnt_q + one_cnt_lp;
      end
    end

    // A beat nobody asked for is dropped and flagged.
    if (app_rd_data_valid_i & ~rd_beat) begin
      error_d = 1'b1;
    end
  end

  // Control state: everything that must be clean after reset, including
  // the sticky error, which only reset can clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_done_q  <= cmd_done_d;
      data_done_q <= data_done_d;
      error_q     <= error_d;
    end
  end

  // Datapath registers carry no reset; they are only observed once the
  // control state says they hold a live request.
  always_ff @(posedge clk_i) begin
    if (req_hs) begin
      write_q <= req_write_i;
      addr_q  <= req_addr_i;
      data_q  <= req_data_i;
      mask_q  <= req_mask_i;
    end
    resp_data_q <= resp_data_d;
  end

endmodule
